// File: rtl/geared_collect_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : geared_collect_scheduler_pkg
// Description : Shared constants for the geared collect scheduler and its
//               phase counter.
// Revision    : 1.0 - initial release
// ============================================================================
package geared_collect_scheduler_pkg;

    // Smallest gear ratio that yields a distinct last-cycle strobe.
    localparam int c_MIN_GEAR_RATIO = 2;

endpackage : geared_collect_scheduler_pkg
`default_nettype wire

// File: rtl/geared_phase_counter.sv
`default_nettype none
// ============================================================================
// Module      : geared_phase_counter
// Description : Gear phase register with wrap, realignment and a strobe for
//               the last fast cycle of each geared period.
// Revision    : 1.0 - initial release
// ============================================================================
module geared_phase_counter
    import geared_collect_scheduler_pkg::*;
#(
    parameter int GEAR_RATIO = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clr_i,
    input  logic                          sync_i,
    output logic [$clog2(GEAR_RATIO)-1:0] phase_o,
    output logic                          last_o
);

    localparam int                 c_IDX_W = $clog2(GEAR_RATIO);
    localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(GEAR_RATIO - 1);

    if (GEAR_RATIO < c_MIN_GEAR_RATIO) begin : g_ratio_check
        $fatal(1, "geared_phase_counter: GEAR_RATIO must be at least 2");
    end

    logic [c_IDX_W-1:0] r_phase;
    logic [c_IDX_W-1:0] w_phase_next;

    // Next phase: realignment forces zero, otherwise increment and wrap.
    always_comb begin
        w_phase_next = r_phase + c_IDX_W'(1);
        if (sync_i || (r_phase == c_LAST)) begin
            w_phase_next = '0;
        end
    end

    // Phase register; a clear also lands on phase 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_phase <= '0;
        end else if (clr_i) begin
            r_phase <= '0;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    assign phase_o = r_phase;
    assign last_o  = (r_phase == c_LAST);

endmodule : geared_phase_counter
`default_nettype wire

// File: rtl/geared_collect_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : geared_collect_scheduler
// Description : Sequencer for the geared-to-narrow collector: gear phase,
//               round-robin one-hot lane select held under backpressure, and
//               a sticky overrun flag for lanes lost at reload.
// Revision    : 1.0 - initial release
// ============================================================================
module geared_collect_scheduler
    import geared_collect_scheduler_pkg::*;
#(
    parameter int GEAR_RATIO = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clr_i,
    input  logic                          gear_sync_i,
    input  logic [GEAR_RATIO-1:0]         valid_i,
    input  logic                          ready_i,
    output logic [$clog2(GEAR_RATIO)-1:0] phase_o,
    output logic                          last_cycle_o,
    output logic [GEAR_RATIO-1:0]         selected_o,
    output logic                          overrun_o,
    output logic                          idle_o
);

    localparam int                    c_IDX_W = $clog2(GEAR_RATIO);
    localparam logic [c_IDX_W-1:0]    c_LAST  = c_IDX_W'(GEAR_RATIO - 1);
    localparam logic [GEAR_RATIO-1:0] c_ONE   = GEAR_RATIO'(1);

    if (GEAR_RATIO < c_MIN_GEAR_RATIO) begin : g_ratio_check
        $fatal(1, "geared_collect_scheduler: GEAR_RATIO must be at least 2");
    end

    logic [GEAR_RATIO-1:0]   r_sel;
    logic [c_IDX_W-1:0]      r_ptr;
    logic                    r_overrun;

    logic                    w_busy;
    logic                    w_hs;
    logic                    w_hold;
    logic [GEAR_RATIO-1:0]   w_mask;
    logic [GEAR_RATIO-1:0]   w_ge_ptr;
    logic [2*GEAR_RATIO-1:0] w_dbl;
    logic                    w_found;
    logic [c_IDX_W-1:0]      w_gidx;
    logic [GEAR_RATIO-1:0]   w_grant;
    logic [c_IDX_W-1:0]      w_ptr_next;

    geared_phase_counter #(
        .GEAR_RATIO (GEAR_RATIO)
    ) u_phase (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (clr_i),
        .sync_i  (gear_sync_i),
        .phase_o (phase_o),
        .last_o  (last_cycle_o)
    );

    // A pending beat on the selected lane either hands off or stalls.
    assign w_busy = |(r_sel & valid_i);
    assign w_hs   = w_busy & ready_i;
    assign w_hold = w_busy & ~ready_i;

    // Lanes still wanting service once this cycle's handshake is accounted.
    assign w_mask = valid_i & ~(w_hs ? r_sel : '0);

    // Lanes at or above the round-robin base get first pick.
    always_comb begin
        w_ge_ptr = '0;
        for (int i = 0; i < GEAR_RATIO; i++) begin
            w_ge_ptr[i] = (i >= int'(r_ptr));
        end
    end

    // Upper copy catches the wrap-around once the lanes above the base are empty.
    assign w_dbl = {w_mask, w_mask & w_ge_ptr};

    // Lowest set bit of the doubled vector, folded back to a lane index.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        for (int i = 2 * GEAR_RATIO - 1; i >= 0; i--) begin
            if (w_dbl[i]) begin
                w_found = 1'b1;
                if (i >= GEAR_RATIO) begin
                    w_gidx = c_IDX_W'(i - GEAR_RATIO);
                end else begin
                    w_gidx = c_IDX_W'(i);
                end
            end
        end
        w_grant    = w_found ? (c_ONE << w_gidx) : '0;
        w_ptr_next = (w_gidx == c_LAST) ? '0 : (w_gidx + c_IDX_W'(1));
    end

    // Selection, round-robin base and sticky overrun.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sel     <= '0;
            r_ptr     <= '0;
            r_overrun <= 1'b0;
        end else if (clr_i) begin
            r_sel     <= '0;
            r_ptr     <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (!w_hold) begin
                r_sel <= w_grant;
                if (w_found) begin
                    r_ptr <= w_ptr_next;
                end
            end
            if (last_cycle_o && (|w_mask)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign selected_o = r_sel;
    assign overrun_o  = r_overrun;
    assign idle_o     = (valid_i == '0) && (r_sel == '0);

endmodule : geared_collect_scheduler
`default_nettype wire

// File: tb/tb_geared_collect_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_geared_collect_scheduler
// Description : Scoreboard bench for geared_collect_scheduler with a lane-level
//               reference model and a behavioural collector driving valid_i.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_geared_collect_scheduler;

    localparam int GR = 4;
    localparam int IW = $clog2(GR);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          gear_sync;
    logic [GR-1:0] valid;
    logic          ready;
    logic [IW-1:0] phase;
    logic          last_cycle;
    logic [GR-1:0] selected;
    logic          overrun;
    logic          idle;

    geared_collect_scheduler #(
        .GEAR_RATIO (GR)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clr_i        (clr),
        .gear_sync_i  (gear_sync),
        .valid_i      (valid),
        .ready_i      (ready),
        .phase_o      (phase),
        .last_cycle_o (last_cycle),
        .selected_o   (selected),
        .overrun_o    (overrun),
        .idle_o       (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        int phase;
        int last;
        int sel;
        int ov;
        int idle;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: lane number of the current grant (-1 = none).
    int      m_phase;
    int      m_sel;
    int      m_ptr;
    bit      m_ov;
    bit [GR-1:0] lanes;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_phase = 0;
        m_sel   = -1;
        m_ptr   = 0;
        m_ov    = 1'b0;
    endfunction

    // Called at negedge+1: apply one cycle of inputs, record what the DUT must
    // show during this cycle, then advance the model past the next rising edge.
    task automatic drive(input bit [GR-1:0] v, input bit r, input bit s, input bit c, output bit hs);
        exp_t        e;
        bit [GR-1:0] cand;
        bit          busy;
        int          nsel;
        valid     = v;
        ready     = r;
        gear_sync = s;
        clr       = c;
        e.phase = m_phase;
        e.last  = (m_phase == GR - 1) ? 1 : 0;
        e.sel   = (m_sel < 0) ? 0 : (1 << m_sel);
        e.ov    = m_ov ? 1 : 0;
        e.idle  = ((v == '0) && (m_sel < 0)) ? 1 : 0;
        q.push_back(e);
        busy = (m_sel >= 0) ? v[m_sel] : 1'b0;
        hs   = busy && r;
        cand = v;
        if (hs) cand[m_sel] = 1'b0;
        if ((m_phase == GR - 1) && (cand != '0)) m_ov = 1'b1;
        if (!(busy && !r)) begin
            nsel = -1;
            for (int j = 0; j < GR; j++) begin
                if ((nsel < 0) && cand[(m_ptr + j) % GR]) nsel = (m_ptr + j) % GR;
            end
            m_sel = nsel;
            if (nsel >= 0) m_ptr = (nsel + 1) % GR;
        end
        m_phase = s ? 0 : (m_phase + 1) % GR;
        if (c) model_reset();
        @(negedge clk);
        #1;
    endtask

    // Collector behaviour: a beat leaves its lane on handshake, and the whole
    // lane set is reloaded after the last cycle of each geared period.
    task automatic coll_cycle(input bit r, input bit [GR-1:0] reload_pat, input bit s, input bit c);
        bit hs;
        int sel_before;
        bit last_before;
        sel_before  = m_sel;
        last_before = (m_phase == GR - 1) && !s;
        drive(lanes, r, s, c, hs);
        if (hs) lanes[sel_before] = 1'b0;
        if (c) lanes = '0;
        else if (last_before) lanes = reload_pat;
    endtask

    // Monitor: compare every presented cycle against the scoreboard.
    initial begin : p_monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("phase", 32'(phase), 32'(e.phase));
                chk("last_cycle", 32'(last_cycle), 32'(e.last));
                chk("selected", 32'(selected), 32'(e.sel));
                chk("overrun", 32'(overrun), 32'(e.ov));
                chk("idle", 32'(idle), 32'(e.idle));
            end
        end
    end

    // Stimulus sequence.
    initial begin : p_stim
        bit hs;
        rst_n     = 1'b0;
        clr       = 1'b0;
        gear_sync = 1'b0;
        valid     = '0;
        ready     = 1'b0;
        lanes     = '0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_last", 32'(last_cycle), 32'd0);
        chk("rst_selected", 32'(selected), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        rst_n = 1'b1;

        // Free run, then realign at phase 1.
        repeat (8) drive('0, 1'b0, 1'b0, 1'b0, hs);
        while (m_phase != 1) drive('0, 1'b0, 1'b0, 1'b0, hs);
        drive('0, 1'b0, 1'b1, 1'b0, hs);
        repeat (5) drive('0, 1'b0, 1'b0, 1'b0, hs);

        // Reloaded 1011 drained at one beat per cycle.
        drive('0, 1'b0, 1'b0, 1'b1, hs);
        lanes = 4'b1011;
        repeat (6) coll_cycle(1'b1, 4'b0000, 1'b0, 1'b0);

        // Stall on lane 1 for three cycles.
        drive('0, 1'b0, 1'b0, 1'b1, hs);
        lanes = 4'b1011;
        coll_cycle(1'b1, 4'b1010, 1'b0, 1'b0);
        coll_cycle(1'b1, 4'b1010, 1'b0, 1'b0);
        repeat (3) coll_cycle(1'b0, 4'b1010, 1'b0, 1'b0);
        repeat (4) coll_cycle(1'b1, 4'b0000, 1'b0, 1'b0);

        // Lane 0 never drained within a period: overrun, then clear.
        drive('0, 1'b0, 1'b0, 1'b1, hs);
        repeat (6) drive(4'b0001, 1'b0, 1'b0, 1'b0, hs);
        drive('0, 1'b0, 1'b0, 1'b1, hs);
        repeat (2) drive('0, 1'b0, 1'b0, 1'b0, hs);

        // Fairness with two permanently valid lanes.
        repeat (12) drive(4'b0101, 1'b1, 1'b0, 1'b0, hs);

        // Randomized traffic.
        drive('0, 1'b0, 1'b0, 1'b1, hs);
        lanes = '0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 15) == 0) lanes = lanes & GR'($urandom);
            coll_cycle($urandom_range(0, 3) != 0, GR'($urandom),
                       $urandom_range(0, 63) == 0, $urandom_range(0, 127) == 0);
        end

        // Asynchronous reset mid-stream drops the selection at once.
        while (m_sel < 0) coll_cycle(1'b0, GR'($urandom), 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_selected", 32'(selected), 32'd0);
        chk("arst_phase", 32'(phase), 32'd0);
        chk("arst_overrun", 32'(overrun), 32'd0);
        model_reset();
        lanes = '0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 15) == 0) lanes = lanes & GR'($urandom);
            coll_cycle($urandom_range(0, 1) != 0, GR'($urandom),
                       $urandom_range(0, 63) == 0, $urandom_range(0, 127) == 0);
        end
        drive('0, 1'b0, 1'b0, 1'b0, hs);

        for (int w = 0; (w < 20) && (q.size() > 0); w++) @(negedge clk);
        #4;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin : p_watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_geared_collect_scheduler
`default_nettype wire

// File: doc/geared_collect_scheduler.md
# geared_collect_scheduler

Sequencer for the geared-to-narrow stream collector in the memory island. It generates the gear phase and the last-cycle-in-gear strobe from the fast clock. It also round-robins the one-hot lane selection across the `GearRatio` captured lanes, holding each selection stable until its beat is accepted downstream. A sticky overrun flag reports any lane still pending when the next geared period reloads the collector.

## Interface
Parameters:
- `GearRatio`, default 2: fast cycles per geared cycle and number of lanes; must be ≥ 2 (`$fatal` otherwise).

Ports:
- `clk_i`, in, 1: fast clock. Single clock domain.
- `rst_ni`, in, 1: asynchronous, active-low reset.
- `clr_i`, in, 1: synchronous clear; returns all state to reset values.
- `gear_sync_i`, in, 1: phase realignment; the next cycle is phase 0.
- `valid_i`, in, `GearRatio`: per-lane captured-valid from the collector.
- `ready_i`, in, 1: downstream ready of the narrow stream.
- `phase_o`, out, `$clog2(GearRatio)`: current gear phase.
- `last_cycle_o`, out, 1: high when `phase_o == GearRatio-1`.
- `selected_o`, out, `GearRatio`: one-hot lane select, or all-zero when idle.
- `overrun_o`, out, 1: sticky, set when a lane is lost at reload.
- `idle_o`, out, 1: high when `valid_i == 0` and `selected_o == 0`.

## Operation
Phase counter:
- `phase_q` resets to 0 and increments by 1 every cycle.
- Wraps from `GearRatio-1` to 0.
- `gear_sync_i` forces the next value to 0; it wins over the increment.
- `last_cycle_o` is combinational from `phase_q`.

Selection state:
- Registers `sel_q` (one-hot) and `ptr_q` (lane index, round-robin base). Both reset to 0.
- A handshake (hs) is `|(sel_q & valid_i) & ready_i`.
- Hold: if `|(sel_q & valid_i)` and `!ready_i`, `sel_q` is unchanged. Selection never changes under a stalled valid beat.
- Arbitrate otherwise:
  - Candidate mask is `valid_i & ~(hs ? sel_q : 0)`.
  - Grant the first set bit at or after `ptr_q`, wrapping modulo `GearRatio`.
  - `sel_q` takes the grant; it is zero if the mask is empty.
  - On a non-zero grant at index k, `ptr_q` becomes `(k+1) mod GearRatio`.
- `selected_o = sel_q` is registered. It feeds both the collector's selected-lane input and its output mux.
- The selected lane's valid may drop without a handshake, for example on a collector clear. In that case arbitration proceeds as above and no error is raised.

Overrun:
- Evaluated in a cycle with `last_cycle_o == 1`.
- Condition: any bit of `valid_i & ~(hs ? sel_q : 0)` is set.
- Result: `overrun_o` is set and stays high until `clr_i` or reset.

## Timing
- Reset and clear values: `phase_o`=0, `last_cycle_o`=0 (1 only if `GearRatio` is 1, which is excluded), `selected_o`=0, `overrun_o`=0, `idle_o`=1 given `valid_i`=0.
- Latency:
  - `valid_i` rise to `selected_o`: 1 cycle.
  - hs to the next lane's select: 1 cycle, so back-to-back lanes run at 1 beat per cycle.
- Maximum throughput is `GearRatio` beats per geared period. Overrun is impossible only if `ready_i` is high on enough cycles to drain every lane before the period ends.
- hs in the last cycle clears that lane normally. Newly reloaded lanes are arbitrated from the following cycle.
- `clr_i` together with `gear_sync_i`: clear wins, and the phase goes to 0 either way.
- Asynchronous reset mid-stream drops the selection immediately; no beat is replayed.

## Structure
- No package types needed.
- Local parameter `IdxW = $clog2(GearRatio)`.
- One natural sub-module: `geared_phase_counter` (phase register, wrap, sync, last strobe). It is reusable by the collector and the geared request path.
- Round-robin arbitration is inline: a double-width masked priority encode.
- All flip-flops use common_cells register macros with asynchronous reset and clear.

## Test plan
- Reset, `GearRatio`=4, free run: `phase_o` cycles 0,1,2,3,0; `last_cycle_o` high on phase 3 only; all other outputs at reset values.
- `gear_sync_i` pulsed at phase 1: next `phase_o`=0 and the counter continues 1,2,3.
- `valid_i`=4'b1011 after a reload, `ready_i`=1, `ptr_q`=0: `selected_o` is 0001, 0010, 1000 on consecutive cycles, then 0000; `overrun_o` stays 0.
- Same `valid_i`, `ready_i` low for 3 cycles on lane 1: `selected_o` holds at 0010 throughout; the order then resumes to 1000.
- `ready_i`=0 for a whole period with `valid_i`=4'b0001: `overrun_o` rises after the last cycle; `clr_i` clears it.
- Fairness: `valid_i` constantly 4'b0101, `ready_i`=1: grants alternate between lane 0 and lane 2, and neither lane is granted twice in a row.
